// File: rtl/slice_writer_pkg.sv
// Shared definitions for the slice write-back path: FSM encoding and frame geometry.
// Imported by the writer top and the slice address counter.
package slice_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned SW_N         = 6;
    localparam int unsigned SW_W         = 25;
    localparam int unsigned SW_FRAME_LEN = 1 << SW_N;

endpackage

// File: rtl/slice_writer_addr_counter.sv
// N-bit slice address counter with synchronous load and increment.
// co_o flags the all-ones address, i.e. the last slice of a frame.
module slice_addr_counter #(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [N-1:0] load_data_i,
    output logic [N-1:0] cnt_o,
    output logic         co_o
);

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    // Load wins over increment; the increment wraps modulo 2^N.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_data_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign co_o  = &cnt_q;

endmodule

// File: rtl/slice_writer.sv
// Writes one frame of 2^N slices from a valid/ready stream to sequential memory
// addresses through a single-entry output register, then pulses done.
module slice_writer
    import slice_writer_pkg::*;
#(
    parameter int unsigned N = SW_N,
    parameter int unsigned W = SW_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [N-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    input  logic         wr_ready,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_valid/in_data come from upstream, in_ready is ours; wr_en
    // and wr_addr/wr_data stay put until the memory raises wr_ready.

    localparam logic [N-1:0] ADDR_ZERO = '0;

    state_e       state_q;
    logic         wr_en_q;
    logic [N-1:0] wr_addr_q;
    logic [W-1:0] wr_data_q;
    logic         busy_q;
    logic         done_q;

    logic [N-1:0] cnt;
    logic         cnt_co;
    logic         cnt_load;
    logic         in_accept;
    logic         wr_accept;

    // The output register can take a new slice when empty or draining this cycle.
    assign in_ready  = (state_q == ST_WRITE) && (!wr_en_q || wr_ready);
    assign in_accept = in_valid && in_ready;
    assign wr_accept = wr_en_q && wr_ready;
    assign cnt_load  = (state_q == ST_IDLE) && start;

    slice_addr_counter #(
        .N (N)
    ) u_addr_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .inc_i       (in_accept),
        .load_i      (cnt_load),
        .load_data_i (ADDR_ZERO),
        .cnt_o       (cnt),
        .co_o        (cnt_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_WRITE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (in_accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt;
                        wr_data_q <= in_data;
                        if (cnt_co) begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (wr_accept) begin
                        wr_en_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Last slice is in the output register; finish once it lands.
                    if (wr_accept) begin
                        wr_en_q <= 1'b0;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_slice_writer.sv
// Directed bench for slice_writer: reset/idle behaviour, full frames, memory
// stalls, input gaps, start during a frame and mid-frame reset.
module tb_slice_writer;
    import slice_writer_pkg::*;

    localparam int unsigned N = SW_N;
    localparam int unsigned W = SW_W;
    localparam logic [W-1:0] DATA_MASK = 25'h1ABCDEF;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         wr_en;
    logic [N-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         wr_ready;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int vectors;
    int miscompares;

    logic [W-1:0] exp_q[$];
    logic [N-1:0] obs_addr_q[$];
    logic [W-1:0] obs_data_q[$];
    logic         stall_rdy_q[$];
    logic [N-1:0] stall_addr_q[$];
    logic [W-1:0] stall_data_q[$];

    int   done_cnt;
    int   done_cycle;
    int   first_wr_cycle;
    int   last_wr_cycle;
    logic busy_at_done;
    logic wr_en_after_done;
    logic busy_after_done;
    logic aborted;
    logic start_pulsed;

    slice_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected write data for slice i is i ^ 25'h1ABCDEF, addresses 0..63.
    task automatic build_exp();
        logic [N-1:0] a;
        exp_q.delete();
        for (int i = 0; i < int'(SW_FRAME_LEN); i++) begin
            a = N'(i);
            exp_q.push_back(DATA_MASK ^ {{(W-N){1'b0}}, a});
        end
    endtask

    // Drives one frame starting in cycle 0 and records what the DUT writes.
    // mode 0 plain, 1 stall at addr 10, 2 input gaps, 3 start at addr 5, 4 reset at addr 40.
    task automatic run_frame(input int mode, input int max_cycles);
        int next_in;
        int stall_n;
        logic [N-1:0] idx;
        next_in = 0;
        stall_n = 0;
        obs_addr_q.delete();
        obs_data_q.delete();
        stall_rdy_q.delete();
        stall_addr_q.delete();
        stall_data_q.delete();
        done_cnt = 0;
        done_cycle = -10;
        first_wr_cycle = -1;
        last_wr_cycle = -1;
        busy_at_done = 1'b0;
        wr_en_after_done = 1'b1;
        busy_after_done = 1'b1;
        aborted = 1'b0;
        start_pulsed = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (mode == 4 && wr_en && wr_addr == N'(40)) begin
                reset_n = 1'b0;
                #1;
                aborted = 1'b1;
                return;
            end
            start = (c == 0);
            if (mode == 3 && !start_pulsed && wr_en && wr_addr == N'(5)) begin
                start = 1'b1;
                start_pulsed = 1'b1;
            end
            in_valid = (mode == 2) ? (c % 2 == 1) : 1'b1;
            idx = N'(next_in);
            in_data = DATA_MASK ^ {{(W-N){1'b0}}, idx};
            wr_ready = 1'b1;
            if (mode == 1 && stall_n < 3 && wr_en && wr_addr == N'(10)) begin
                wr_ready = 1'b0;
                stall_n++;
            end
            #1;
            if (!wr_ready) begin
                stall_rdy_q.push_back(in_ready);
                stall_addr_q.push_back(wr_addr);
                stall_data_q.push_back(wr_data);
            end
            if (wr_en && wr_ready) begin
                obs_addr_q.push_back(wr_addr);
                obs_data_q.push_back(wr_data);
                if (first_wr_cycle < 0) first_wr_cycle = c;
                last_wr_cycle = c;
            end
            if (done) begin
                done_cnt++;
                done_cycle = c;
                busy_at_done = busy;
            end
            if (done_cnt > 0 && c == done_cycle + 1) begin
                wr_en_after_done = wr_en;
                busy_after_done = busy;
            end
            if (in_valid && in_ready) next_in++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = DATA_MASK;
        wr_ready = 1'b1;
        #1;
        vectors++;
        if ({in_ready, wr_en, busy, done} !== 4'b0000 || wr_addr !== '0 || wr_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy/en/busy/done=%b addr=%0h data=%0h expected 0000/0/0",
                     {in_ready, wr_en, busy, done}, wr_addr, wr_data);
        end
        vectors++;
        if (dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({in_ready, wr_en, busy, done} !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle_no_start: cycle %0d got rdy/en/busy/done=%b expected 0000",
                         c, {in_ready, wr_en, busy, done});
            end
        end
    endtask

    task automatic test_full_frame();
        logic [N-1:0] a;
        run_frame(0, 80);
        vectors++;
        if (obs_addr_q.size() != 64) begin
            miscompares++;
            $display("FAIL full_write_count: got %0d expected 64", obs_addr_q.size());
        end
        foreach (obs_addr_q[i]) begin
            a = N'(i);
            vectors++;
            if (i >= 64 || obs_addr_q[i] !== a || obs_data_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL full_write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                         i, obs_addr_q[i], obs_data_q[i], a, (i < 64) ? exp_q[i] : '0);
            end
        end
        vectors++;
        if (first_wr_cycle != 2) begin
            miscompares++;
            $display("FAIL full_first_write_cycle: got %0d expected 2", first_wr_cycle);
        end
        vectors++;
        if (done_cnt != 1 || done_cycle != 66) begin
            miscompares++;
            $display("FAIL full_done: got count=%0d cycle=%0d expected count=1 cycle=66", done_cnt, done_cycle);
        end
        vectors++;
        if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0 || wr_en_after_done !== 1'b0) begin
            miscompares++;
            $display("FAIL full_after_done: got busy@66=%b busy@67=%b wr_en@67=%b expected 1 0 0",
                     busy_at_done, busy_after_done, wr_en_after_done);
        end
    endtask

    task automatic test_mem_stall();
        logic [N-1:0] a;
        run_frame(1, 100);
        vectors++;
        if (stall_rdy_q.size() != 3) begin
            miscompares++;
            $display("FAIL stall_cycles: got %0d expected 3", stall_rdy_q.size());
        end
        foreach (stall_rdy_q[i]) begin
            vectors++;
            if (stall_rdy_q[i] !== 1'b0 || stall_addr_q[i] !== N'(10) || stall_data_q[i] !== (DATA_MASK ^ 25'd10)) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got rdy=%b addr=%0d data=%0h expected rdy=0 addr=10 data=%0h",
                         i, stall_rdy_q[i], stall_addr_q[i], stall_data_q[i], DATA_MASK ^ 25'd10);
            end
        end
        vectors++;
        if (obs_addr_q.size() != 64) begin
            miscompares++;
            $display("FAIL stall_write_count: got %0d expected 64", obs_addr_q.size());
        end
        foreach (obs_addr_q[i]) begin
            a = N'(i);
            vectors++;
            if (i >= 64 || obs_addr_q[i] !== a || obs_data_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stall_write[%0d]: got addr=%0d data=%0h expected addr=%0d",
                         i, obs_addr_q[i], obs_data_q[i], a);
            end
        end
        vectors++;
        if (done_cnt != 1 || done_cycle != 69) begin
            miscompares++;
            $display("FAIL stall_done: got count=%0d cycle=%0d expected count=1 cycle=69", done_cnt, done_cycle);
        end
    endtask

    task automatic test_input_gaps();
        logic [N-1:0] a;
        run_frame(2, 200);
        vectors++;
        if (obs_addr_q.size() != 64) begin
            miscompares++;
            $display("FAIL gaps_write_count: got %0d expected 64", obs_addr_q.size());
        end
        foreach (obs_addr_q[i]) begin
            a = N'(i);
            vectors++;
            if (i >= 64 || obs_addr_q[i] !== a || obs_data_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL gaps_write[%0d]: got addr=%0d data=%0h expected addr=%0d",
                         i, obs_addr_q[i], obs_data_q[i], a);
            end
        end
        vectors++;
        if (last_wr_cycle != 128 || done_cnt != 1 || done_cycle != last_wr_cycle + 1) begin
            miscompares++;
            $display("FAIL gaps_done: got last_wr=%0d done=%0d count=%0d expected last_wr=128 done=129 count=1",
                     last_wr_cycle, done_cycle, done_cnt);
        end
    endtask

    task automatic test_start_in_write();
        logic [N-1:0] a;
        run_frame(3, 80);
        vectors++;
        if (start_pulsed !== 1'b1 || obs_addr_q.size() != 64) begin
            miscompares++;
            $display("FAIL restart_write_count: got pulsed=%b writes=%0d expected 1 64",
                     start_pulsed, obs_addr_q.size());
        end
        foreach (obs_addr_q[i]) begin
            a = N'(i);
            vectors++;
            if (i >= 64 || obs_addr_q[i] !== a || obs_data_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL restart_write[%0d]: got addr=%0d data=%0h expected addr=%0d",
                         i, obs_addr_q[i], obs_data_q[i], a);
            end
        end
        vectors++;
        if (done_cnt != 1 || done_cycle != 66) begin
            miscompares++;
            $display("FAIL restart_done: got count=%0d cycle=%0d expected count=1 cycle=66", done_cnt, done_cycle);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [N-1:0] a;
        run_frame(4, 80);
        vectors++;
        if (aborted !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_reached_addr40: got %b expected 1", aborted);
        end
        vectors++;
        if ({in_ready, wr_en, busy, done} !== 4'b0000 || wr_addr !== '0 || wr_data !== '0) begin
            miscompares++;
            $display("FAIL midreset_async_clear: got rdy/en/busy/done=%b addr=%0d data=%0h expected 0000/0/0",
                     {in_ready, wr_en, busy, done}, wr_addr, wr_data);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0 || wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_held: cycle %0d got done=%b wr_en=%b expected 0 0", c, done, wr_en);
            end
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0, 80);
        vectors++;
        if (obs_addr_q.size() != 64 || done_cnt != 1 || done_cycle != 66) begin
            miscompares++;
            $display("FAIL midreset_new_frame: got writes=%0d done_count=%0d done_cycle=%0d expected 64 1 66",
                     obs_addr_q.size(), done_cnt, done_cycle);
        end
        foreach (obs_addr_q[i]) begin
            a = N'(i);
            vectors++;
            if (i >= 64 || obs_addr_q[i] !== a || obs_data_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midreset_write[%0d]: got addr=%0d data=%0h expected addr=%0d",
                         i, obs_addr_q[i], obs_data_q[i], a);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        build_exp();
        test_reset();
        test_full_frame();
        test_mem_stall();
        test_input_gaps();
        test_start_in_write();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slice_writer.md
# slice_writer

Output-side counterpart of the column-parity read path. It accepts processed 25-bit slices over a valid/ready stream and writes them back to the output memory at sequential slice addresses 0..2^N-1. It then signals completion. It sits between the parity/theta datapath and the output memory, mirroring the read-side slice address counter.

## Interface
- N, 6, slice address width; one frame = 2^N slices
- W, 25, slice width in bits (5x5 slice)

- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin a frame; sampled only in IDLE
- in_valid  input  1  upstream slice valid
- in_data  input  W  upstream slice
- in_ready  output  1  writer can accept in_data this cycle
- wr_en  output  1  memory write request (held until accepted)
- wr_addr  output  N  slice address of current write
- wr_data  output  W  slice to write
- wr_ready  input  1  memory accepts write this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the last write of a frame is accepted

## Operation
- Reset values: state IDLE; address counter 0; wr_en 0, wr_addr 0, wr_data 0, in_ready 0, busy 0, done 0.
- FSM states: IDLE, WRITE, DRAIN, DONE.
  - IDLE: start=1 moves to WRITE and loads the counter with 0. Any other input is ignored.
  - WRITE: in_ready = !wr_en || wr_ready (single-entry output register, full throughput).
    - Input accept = in_valid && in_ready.
    - On accept: the output register loads wr_data<=in_data and wr_addr<=counter, and sets wr_en<=1. The counter then increments.
    - Accepting the slice with counter == 2^N-1 moves to DRAIN. The counter wraps to 0 and that wrap is not an error.
  - DRAIN: in_ready=0. The FSM waits for wr_en && wr_ready, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Write accept (wr_en && wr_ready) with no simultaneous input accept clears wr_en next cycle.
- Write accept and input accept in the same cycle leaves wr_en=1 with the new data and address (back-to-back).
- wr_addr/wr_data are stable while wr_en=1 && wr_ready=0.
- start outside IDLE has no effect. start in the same cycle that DONE returns to IDLE is also ignored, because it is sampled the following cycle.
- Address arithmetic is unsigned, modulo 2^N. Exactly 2^N writes are issued per frame, addresses strictly ascending from 0.
- reset_n low at any time, including mid-frame with wr_en=1: everything returns to reset values immediately. The pending write is dropped and no done is issued.

## Timing
- Input-to-write latency: 1 cycle. A slice accepted in cycle t appears on wr_* with wr_en=1 in cycle t+1.
- Sustained throughput: 1 slice/cycle while wr_ready=1 and in_valid=1.
- Frame with no stalls: start in cycle 0, first input accept in cycle 1, last accept in cycle 2^N. DONE is reached in cycle 2^N+2, with done high in that cycle, and busy falls in cycle 2^N+3.
- in_ready is combinational from state, wr_en and wr_ready. There is no combinational path from in_valid to in_ready.
- Memory stall of k cycles on the last write extends DRAIN by k cycles.

## Structure
- Shared package: the state encoding (IDLE/WRITE/DRAIN/DONE), the default N and W, and a frame-length constant 2^N.
- One natural sub-module: slice_addr_counter. It is an N-bit counter with inc, load, load_data and carry-out (co = all ones), async active-low reset. The FSM uses co as the "last slice" flag.

## Test plan
- Reset then idle, with in_valid=1 and no start: in_ready=0, wr_en=0, busy=0, done=0 indefinitely.
- N=6, start, 64 slices with in_data=address^25'h1ABCDEF and wr_ready=1: 64 writes at addr 0..63 with matching data, done pulses once at cycle 66, no write at cycle 67.
- wr_ready low for 3 cycles when addr=10: wr_addr=10/data held, in_ready=0 for those cycles, slice 11 is not lost, and the sequence resumes in order.
- in_valid gaps (every other cycle): writes still ascend 0..63 with no duplicates. done follows the last write accept by 1 cycle.
- start asserted during WRITE at addr 5: no restart, counter continues 6, 7, ..., and there is a single done.
- reset_n pulsed low while wr_en=1 at addr 40: all outputs go to 0 asynchronously, no done. A new start produces a clean frame beginning at addr 0.
